// File: rtl/alu_input_ctrl_if.sv
// alu_input_ctrl_if: switch/button inputs, ALU feedback and registered operand outputs of alu_input_ctrl
interface alu_input_ctrl_if #(parameter int N = 4);
  logic [N-1:0] sw;
  logic         btn_next;
  logic         btn_sum;
  logic         btn_subt;
  logic [N-1:0] alu_result;
  logic         alu_carry;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         op_sum;
  logic         op_subt;
  logic [N-1:0] result_q;
  logic         carry_q;
  logic         valid;
  logic [2:0]   state;
  modport slave (
    input  sw, btn_next, btn_sum, btn_subt, alu_result, alu_carry,
    output a, b, op, op_sum, op_subt, result_q, carry_q, valid, state
  );
  modport master (
    output sw, btn_next, btn_sum, btn_subt, alu_result, alu_carry,
    input  a, b, op, op_sum, op_subt, result_q, carry_q, valid, state
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl: button-driven operand/opcode entry FSM that feeds an ALU and captures its result.
// Optional debounce filtering is enabled by defining ALU_INPUT_CTRL_DEBOUNCE_EN.
module alu_input_ctrl #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  alu_input_ctrl_if.slave bus
);
  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SHOW    = 3'd4;
  logic [2:0]   raw, sync1, sync2, level, prev, armed, ev;
  logic [1:0]   fill;
  logic         ev_next, ev_sum, ev_subt;
  logic [2:0]   st;
  logic [N-1:0] a_q, b_q, res_q;
  logic [2:0]   op_q;
  logic         sum_q, subt_q, carry_q, valid_q;
  assign raw = {bus.btn_subt, bus.btn_sum, bus.btn_next};
  // a button is armed only once it has been seen released after reset, so a press held through reset is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      armed <= '0;
      fill  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= level;
      fill  <= {fill[0], 1'b1};
      armed <= armed | ({3{fill[1]}} & sync2);
    end
  end
`ifdef ALU_INPUT_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic          d;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d   <= 1'b1;
        cnt <= '0;
      end else if (sync2[i] == d) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        d   <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign level[i] = d;
  end
`else
  assign level = sync2;
`endif
  assign ev      = armed & prev & ~level;
  assign ev_next = ev == 3'b001;
  assign ev_sum  = ev == 3'b010;
  assign ev_subt = ev == 3'b100;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sum_q   <= 1'b0;
      subt_q  <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (st)
        LOAD_A: if (ev_next) begin
          a_q <= bus.sw;
          st  <= LOAD_B;
        end
        LOAD_B: if (ev_next) begin
          b_q <= bus.sw;
          st  <= LOAD_OP;
        end
        LOAD_OP: if (ev_next || ev_sum || ev_subt) begin
          op_q   <= ev_next ? bus.sw[2:0] : op_q;
          sum_q  <= ev_sum;
          subt_q <= ev_subt;
          st     <= EXEC;
        end
        EXEC: begin
          res_q   <= bus.alu_result;
          carry_q <= bus.alu_carry;
          valid_q <= 1'b1;
          st      <= SHOW;
        end
        SHOW: if (ev_next) begin
          valid_q <= 1'b0;
          st      <= LOAD_A;
        end
        default: st <= LOAD_A;
      endcase
    end
  end
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.op       = op_q;
  assign bus.op_sum   = sum_q;
  assign bus.op_subt  = subt_q;
  assign bus.result_q = res_q;
  assign bus.carry_q  = carry_q;
  assign bus.valid    = valid_q;
  assign bus.state    = st;
endmodule

// File: doc/alu_input_ctrl.md
ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 Parameter N, default 4, operand/result width in bits.
REQ-002 Parameter DB_CYCLES, default 16, debounce stable-count threshold (used only when the macro in REQ-031 is defined).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 sw  input  N  slide-switch value loaded as operand or opcode.
REQ-006 btn_next  input  1  push button, low = pressed; advances entry.
REQ-007 btn_sum  input  1  push button, low = pressed; requests add.
REQ-008 btn_subt  input  1  push button, low = pressed; requests subtract.
REQ-009 alu_result  input  N  combinational ALU result.
REQ-010 alu_carry  input  1  combinational ALU carry/borrow.
REQ-011 a  output  N  registered operand A to ALU.
REQ-012 b  output  N  registered operand B to ALU.
REQ-013 op  output  3  registered ALU opcode.
REQ-014 op_sum  output  1  registered add select, 1 = add.
REQ-015 op_subt  output  1  registered subtract select, 1 = subtract.
REQ-016 result_q  output  N  captured ALU result.
REQ-017 carry_q  output  1  captured ALU carry.
REQ-018 valid  output  1  high while result_q/carry_q hold a fresh capture.
REQ-019 state  output  3  current FSM state encoding (LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4).

Function
REQ-020 Each button SHALL pass a 2-FF synchronizer; a press event SHALL be a single-cycle pulse on a synchronized 1->0 transition; holding a button SHALL yield exactly one event.
REQ-021 LOAD_A: next event SHALL latch a<=sw and go to LOAD_B; sum/subt events ignored.
REQ-022 LOAD_B: next event SHALL latch b<=sw and go to LOAD_OP; sum/subt events ignored.
REQ-023 LOAD_OP: next event SHALL latch op<=sw[2:0], op_sum<=0, op_subt<=0, go to EXEC.
REQ-024 LOAD_OP: sum event SHALL set op_sum<=1, op_subt<=0, keep op, go to EXEC; subt event SHALL set op_subt<=1, op_sum<=0, go to EXEC.
REQ-025 Two or more events in the same cycle in any state SHALL be ignored (no state or register change).
REQ-026 EXEC SHALL last exactly one cycle with a/b/op/op_sum/op_subt stable; on exit result_q<=alu_result, carry_q<=alu_carry, valid<=1, state<=SHOW (capture latency = 1 cycle after entering EXEC).
REQ-027 SHOW: outputs hold; next event SHALL clear valid and go to LOAD_A; a, b, op, op_sum, op_subt keep prior values until re-latched.
REQ-028 Events arriving in EXEC SHALL be discarded, not queued.

Reset
REQ-029 On rst high, immediately: state=LOAD_A; a, b, result_q = 0; op=0; op_sum, op_subt, carry_q, valid = 0; synchronizer and edge flops = 1 (not pressed).
REQ-030 A button held low through reset deassertion SHALL NOT produce an event until released and pressed again; reset mid-EXEC SHALL discard the capture.

Configuration
REQ-031 Macro ALU_INPUT_CTRL_DEBOUNCE_EN: when defined, each synchronized button SHALL be considered pressed only after remaining low for DB_CYCLES consecutive cycles (and released after DB_CYCLES high); the event fires on the debounced 1->0 transition. When undefined, events derive directly from the synchronized level (REQ-020) with no counters instantiated.

Verification
REQ-032 sw=1000, next; sw=0010, next; sw=101 (3'b101), next; alu_result=1010, alu_carry=0 -> a=1000, b=0010, op=101, state SHOW, result_q=1010, valid=1, 1 cycle after EXEC entry.
REQ-033 a=1111, b=1000 loaded, sum event in LOAD_OP, alu_result=0111, alu_carry=1 -> op_sum=1, op_subt=0, result_q=0111, carry_q=1.
REQ-034 In LOAD_OP, btn_sum and btn_subt pressed same cycle -> state stays LOAD_OP, op_sum=op_subt=0; then subt alone -> op_subt=1, EXEC.
REQ-035 btn_next held low 50 cycles in LOAD_A -> exactly one transition to LOAD_B.
REQ-036 rst asserted during EXEC -> same-cycle state=LOAD_A, valid=0, result_q=0; btn_next held through deassertion -> no event until release/press.
REQ-037 With ALU_INPUT_CTRL_DEBOUNCE_EN, DB_CYCLES=16: 5-cycle low glitch on btn_next -> no event; 20-cycle low press -> one event.
